// File: rtl/ddr3_rd_resp_if.sv
// DDR3 read-response bundle: command reservation, DFI return, AXI R.
// The DUT takes the slave view, the surrounding logic the master view.
interface ddr3_rd_resp_if #(
  parameter int PHY_DAT_BITS = 32,
  parameter int AXI_ID_WIDTH = 4
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [AXI_ID_WIDTH-1:0] cmd_id_i;
  logic                    cmd_last_i;
  logic                    dfi_valid_i;
  logic [PHY_DAT_BITS-1:0] dfi_data_i;
  logic                    axi_rvalid_o;
  logic                    axi_rready_i;
  logic                    axi_rlast_o;
  logic [1:0]              axi_rresp_o;
  logic [AXI_ID_WIDTH-1:0] axi_rid_o;
  logic [PHY_DAT_BITS-1:0] axi_rdata_o;
  logic                    error_o;

  modport slave (
    input  cmd_valid_i, cmd_id_i, cmd_last_i,
    input  dfi_valid_i, dfi_data_i, axi_rready_i,
    output cmd_ready_o, axi_rvalid_o, axi_rlast_o,
    output axi_rresp_o, axi_rid_o, axi_rdata_o, error_o
  );

  modport master (
    output cmd_valid_i, cmd_id_i, cmd_last_i,
    output dfi_valid_i, dfi_data_i, axi_rready_i,
    input  cmd_ready_o, axi_rvalid_o, axi_rlast_o,
    input  axi_rresp_o, axi_rid_o, axi_rdata_o, error_o
  );
endinterface

// File: rtl/ddr3_rd_resp.sv
// DDR3 read-response stage: buffers DFI read data, tags it with
// the AXI ID and replays it on the AXI R channel.
module ddr3_rd_resp #(
  parameter int PHY_DAT_BITS = 32,
  parameter int AXI_ID_WIDTH = 4,
  parameter int PHY_BURSTLEN = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input logic            clock,
  input logic            reset,
  ddr3_rd_resp_if.slave  bus
);
  localparam int TD  = FIFO_DEPTH / PHY_BURSTLEN;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(TD);
  localparam int TCW = TW + 1;
  localparam int BW  = $clog2(PHY_BURSTLEN);

  logic [PHY_DAT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AXI_ID_WIDTH:0]   tmem [TD];

  logic [AW:0]   wptr, rptr;
  logic [TW:0]   twp, trp;
  logic [CW-1:0] rsv, rsv_nx;
  logic [CW-1:0] pend, pend_nx;
  logic [TCW-1:0] tcnt, tcnt_nx;
  logic [BW-1:0] bcnt;

  logic rvalid_q, cmd_ready_q, err_q;
  logic [PHY_DAT_BITS-1:0] rdata_q;
  logic [AXI_ID_WIDTH:0]   tag_head;

  logic cmd_hs, r_hs, beat_ok, beat_drop;
  logic fifo_empty, load, avail, bypass, push, pop, tag_pop;
  logic cmd_ready_nx;

  assign cmd_hs     = bus.cmd_valid_i & cmd_ready_q;
  assign r_hs       = rvalid_q & bus.axi_rready_i;
  assign beat_ok    = bus.dfi_valid_i & (pend != '0);
  assign beat_drop  = bus.dfi_valid_i & (pend == '0);
  assign fifo_empty = (wptr == rptr);
  assign tag_head   = tmem[trp[TW-1:0]];
  assign tag_pop    = r_hs & (bcnt == BW'(PHY_BURSTLEN - 1));
  assign tcnt       = TCW'(twp - trp);

  // Output register is free when empty or being consumed this cycle;
  // an empty FIFO lets a fresh DFI beat bypass straight into it.
  assign load   = ~rvalid_q | bus.axi_rready_i;
  assign avail  = ~fifo_empty | beat_ok;
  assign bypass = load & fifo_empty & beat_ok;
  assign pop    = load & ~fifo_empty;
  assign push   = beat_ok & ~bypass;

  always_comb begin
    rsv_nx  = rsv;
    pend_nx = pend;
    tcnt_nx = tcnt;
    if (cmd_hs) begin
      rsv_nx  = rsv_nx + CW'(PHY_BURSTLEN);
      pend_nx = pend_nx + CW'(PHY_BURSTLEN);
      tcnt_nx = tcnt_nx + TCW'(1);
    end
    if (r_hs)    rsv_nx  = rsv_nx - CW'(1);
    if (beat_ok) pend_nx = pend_nx - CW'(1);
    if (tag_pop) tcnt_nx = tcnt_nx - TCW'(1);
    cmd_ready_nx = (rsv_nx <= CW'(FIFO_DEPTH - PHY_BURSTLEN))
                 && (tcnt_nx < TCW'(TD));
  end

  always_ff @(posedge clock) begin
    if (push)   mem[wptr[AW-1:0]] <= bus.dfi_data_i;
    if (cmd_hs) tmem[twp[TW-1:0]] <= {bus.cmd_id_i, bus.cmd_last_i};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      twp         <= '0;
      trp         <= '0;
      rsv         <= '0;
      pend        <= '0;
      bcnt        <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push)    wptr <= wptr + (AW+1)'(1);
      if (pop)     rptr <= rptr + (AW+1)'(1);
      if (cmd_hs)  twp  <= twp + TCW'(1);
      if (tag_pop) trp  <= trp + TCW'(1);
      if (r_hs)    bcnt <= bcnt + BW'(1);
      rsv         <= rsv_nx;
      pend        <= pend_nx;
      cmd_ready_q <= cmd_ready_nx;
      if (beat_drop) err_q <= 1'b1;
      if (load) rvalid_q <= avail;
      if (load && avail)
        rdata_q <= fifo_empty ? bus.dfi_data_i : mem[rptr[AW-1:0]];
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.axi_rvalid_o = rvalid_q;
  assign bus.axi_rdata_o  = rdata_q;
  assign bus.axi_rresp_o  = 2'b00;
  assign bus.axi_rid_o    = rvalid_q ? tag_head[AXI_ID_WIDTH:1] : '0;
  assign bus.axi_rlast_o  = rvalid_q & tag_head[0]
                          & (bcnt == BW'(PHY_BURSTLEN - 1));
  assign bus.error_o      = err_q;
endmodule

// File: tb/tb_ddr3_rd_resp.sv
// Directed bench for ddr3_rd_resp with a beat scoreboard.
// Expected beats are queued when DFI data is driven, popped on R handshakes.
module tb_ddr3_rd_resp;
  typedef struct {
    logic [3:0]  id;
    logic        last;
    logic [31:0] data;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  beat_t exp_q[$];
  beat_t got_q[$];

  ddr3_rd_resp_if #(.PHY_DAT_BITS(32), .AXI_ID_WIDTH(4)) bus ();

  ddr3_rd_resp #(
    .PHY_DAT_BITS(32), .AXI_ID_WIDTH(4),
    .PHY_BURSTLEN(4), .FIFO_DEPTH(16)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.axi_rvalid_o && bus.axi_rready_i) begin
      beat_t b;
      b.id = bus.axi_rid_o;
      b.last = bus.axi_rlast_o;
      b.data = bus.axi_rdata_o;
      b.cyc = cyc;
      got_q.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic last);
    int w = 0;
    while (!bus.cmd_ready_o && w < 100) begin
      tick();
      w++;
    end
    if (!bus.cmd_ready_o) begin
      checks++;
      failures++;
      $error("FAIL cmd_wait observed=0 expected=1");
    end
    bus.cmd_valid_i = 1'b1;
    bus.cmd_id_i = id;
    bus.cmd_last_i = last;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  logic rv_before, rv_after1;

  task automatic dfi_burst(input logic [3:0] id, input logic last,
                           input logic [31:0] base,
                           input logic [31:0] step);
    for (int i = 0; i < 4; i++) begin
      beat_t e;
      e.id = id;
      e.last = last && (i == 3);
      e.data = base + step * i;
      e.cyc = 0;
      exp_q.push_back(e);
      if (i == 0) rv_before = bus.axi_rvalid_o;
      bus.dfi_valid_i = 1'b1;
      bus.dfi_data_i = e.data;
      tick();
      if (i == 0) rv_after1 = bus.axi_rvalid_o;
    end
    bus.dfi_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag, input bit consec);
    int lastc = 0;
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      beat_t e, g;
      int w = 0;
      while (got_q.size() == 0 && w < 200) begin
        tick();
        w++;
      end
      if (got_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s_timeout observed=%0d expected=%0d",
               tag, 0, exp_q.size());
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, g.data, e.data);
      chk({tag, "_id"}, g.id, e.id);
      chk({tag, "_last"}, g.last, e.last);
      if (consec && !first) chk({tag, "_gap"}, g.cyc - lastc, 1);
      lastc = g.cyc;
      first = 1'b0;
    end
  endtask

  initial begin
    int n;
    bit hs;
    bus.cmd_valid_i = 0;
    bus.cmd_id_i = 0;
    bus.cmd_last_i = 0;
    bus.dfi_valid_i = 0;
    bus.dfi_data_i = 0;
    bus.axi_rready_i = 0;

    // reset state
    repeat (3) tick();
    chk("rst_ready", bus.cmd_ready_o, 0);
    chk("rst_rvalid", bus.axi_rvalid_o, 0);
    chk("rst_err", bus.error_o, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rel_ready", bus.cmd_ready_o, 1);
    chk("rel_rvalid", bus.axi_rvalid_o, 0);

    // 1: single burst, one-cycle latency, back-to-back stream
    bus.axi_rready_i = 1'b1;
    send_cmd(4'd3, 1'b1);
    dfi_burst(4'd3, 1'b1, 32'h11, 32'h11);
    chk("t1_rv_pre", rv_before, 0);
    chk("t1_rv_lat", rv_after1, 1);
    drain("t1", 1'b1);

    // 2: two bursts of one transaction
    send_cmd(4'd5, 1'b0);
    send_cmd(4'd5, 1'b1);
    dfi_burst(4'd5, 1'b0, 32'hA000_0000, 32'h1);
    dfi_burst(4'd5, 1'b1, 32'hA000_0010, 32'h1);
    drain("t2", 1'b0);
    tick();
    tick();
    chk("t2_rsv", dut.rsv, 0);
    chk("t2_ready", bus.cmd_ready_o, 1);

    // 3: fill reservation with rready low
    bus.axi_rready_i = 1'b0;
    for (int b = 1; b <= 4; b++) send_cmd(4'(b), 1'b1);
    chk("t3_full_ready", bus.cmd_ready_o, 0);
    for (int b = 1; b <= 4; b++)
      dfi_burst(4'(b), 1'b1, 32'(b) << 8, 32'h1);
    tick();
    chk("t3_rvalid", bus.axi_rvalid_o, 1);
    chk("t3_rresp", bus.axi_rresp_o, 0);
    chk("t3_rlast", bus.axi_rlast_o, 0);
    chk("t3_rsv", dut.rsv, 16);
    bus.axi_rready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 8 && !bus.cmd_ready_o; c++) begin
      hs = bus.axi_rvalid_o && bus.axi_rready_i;
      tick();
      n += int'(hs);
      chk("t3_ready_step", bus.cmd_ready_o, (n >= 4));
    end
    chk("t3_hs_count", n, 4);

    // 4: cmd and R handshakes in one cycle at rsv=12
    chk("t4_rvalid", bus.axi_rvalid_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_id_i = 4'd9;
    bus.cmd_last_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
    chk("t4_ready", bus.cmd_ready_o, 0);
    chk("t4_rsv", dut.rsv, 15);
    dfi_burst(4'd9, 1'b1, 32'hC0DE_0000, 32'h3);
    drain("t34", 1'b0);
    tick();
    tick();
    chk("t4_rsv_end", dut.rsv, 0);

    // 5: unexpected DFI beat
    bus.dfi_valid_i = 1'b1;
    bus.dfi_data_i = 32'hDEAD;
    tick();
    bus.dfi_valid_i = 1'b0;
    chk("t5_err", bus.error_o, 1);
    chk("t5_rvalid", bus.axi_rvalid_o, 0);
    repeat (3) tick();
    chk("t5_err_sticky", bus.error_o, 1);
    chk("t5_rvalid2", bus.axi_rvalid_o, 0);

    // 6: reset mid-burst
    bus.axi_rready_i = 1'b0;
    send_cmd(4'd7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.dfi_valid_i = 1'b1;
      bus.dfi_data_i = 32'h7700 + 32'(i);
      tick();
    end
    bus.dfi_valid_i = 1'b0;
    chk("t6_pre_rvalid", bus.axi_rvalid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rvalid", bus.axi_rvalid_o, 0);
    chk("t6_rid", bus.axi_rid_o, 0);
    chk("t6_rdata", bus.axi_rdata_o, 0);
    chk("t6_ready", bus.cmd_ready_o, 0);
    chk("t6_err", bus.error_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_rel_ready", bus.cmd_ready_o, 1);
    chk("t6_rel_rvalid", bus.axi_rvalid_o, 0);
    chk("t6_rel_err", bus.error_o, 0);
    for (int i = 2; i < 4; i++) begin
      bus.dfi_valid_i = 1'b1;
      bus.dfi_data_i = 32'h7700 + 32'(i);
      tick();
    end
    bus.dfi_valid_i = 1'b0;
    chk("t6_stale_err", bus.error_o, 1);
    chk("t6_stale_rvalid", bus.axi_rvalid_o, 0);
    chk("t6_got_empty", got_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
